shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//  Receive end of the shift-register serial link: collects a bit stream produced by a
//  shifting GPR-style serializer and presents each completed word in parallel with a
//  valid/ready handshake. Shift register and output holding register are separate, so
//  reception continues while a finished word waits for the consumer.
// PARAMETERS
//  WIDTH      4  data bits per word (>=2)
//  MSB_FIRST  1  1: first received bit lands in P[WIDTH-1]; 0: first bit lands in P[0]
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  CLR        in   1      asynchronous, active-low reset
//  sd_in      in   1      serial data bit
//  sd_en      in   1      bit strobe; sd_in sampled only when sd_en=1
//  sd_start   in   1      with sd_en=1, marks the current bit as the first bit of a word
//  p_ready    in   1      consumer accepts P this cycle when p_valid=1
//  ovr_clr    in   1      clears sticky overrun flag
//  P          out  WIDTH  received word (stable while p_valid=1)
//  p_valid    out  1      P holds an unconsumed word
//  overrun    out  1      sticky: a completed word was dropped
//  parity_err out  1      parity status of word in P (DESER_PARITY_EN only; else 0)
// BEHAVIOUR
//  - Reset (CLR=0, any time, async): state=IDLE, bit count=0, shift reg=0, P=0,
//    p_valid=0, overrun=0, parity_err=0. Partial word discarded.
//  - FSM: IDLE -> RECV on sd_en&sd_start (that bit is bit 0). RECV counts sampled bits;
//    when count reaches WIDTH: -> IDLE (or -> PAR with macro). Bits with sd_en=1 and
//    sd_start=0 in IDLE are ignored. Cycles with sd_en=0 hold all state.
//  - sd_en&sd_start while in RECV/PAR: partial word discarded, restart with this bit as
//    bit 0; no error flagged.
//  - Bit placement: MSB_FIRST=1 -> shift left, new bit into LSB; MSB_FIRST=0 -> shift
//    right, new bit into MSB. After WIDTH bits the first bit sits at the parameterised end.
//  - Completion: on the edge that samples the final bit, word is written to P and
//    p_valid rises (visible cycle after last bit strobe). Latency = 1 clock.
//  - Handshake: transfer when p_valid&p_ready; p_valid falls next edge unless a new word
//    completes on that same edge, in which case P loads new word, p_valid stays 1, no overrun.
//  - Completion while p_valid=1 and p_ready=0: new word dropped, P unchanged, overrun
//    set next edge. overrun stays 1 until ovr_clr=1 (clear wins over simultaneous set: no;
//    set wins -- a drop in the ovr_clr cycle leaves overrun=1).
//  - P and p_valid never change while p_valid=1 and p_ready=0.
// CONFIGURATION
//  DESER_PARITY_EN defined: each word is WIDTH data bits followed by one even-parity bit
//    (state PAR). On the parity-bit strobe, P/p_valid update as above and parity_err =
//    XOR(data bits, parity bit); parity_err tracks P and is dropped with it on overrun.
//    Completion latency counts from the parity-bit strobe.
//  DESER_PARITY_EN undefined: no PAR state, word ends after WIDTH bits, parity_err=0.
// TESTING
//  1 Reset: drive CLR=0 mid-word -> P=0, p_valid=0, overrun=0 immediately (no clock).
//  2 MSB_FIRST=1, bits 1,0,1,1 (start on first), p_ready=1 -> P=4'b1011, p_valid one
//    cycle, then 0.
//  3 MSB_FIRST=0, same stream -> P=4'b1101.
//  4 p_ready=0, send 4'hA then 4'h5 -> P stays 4'hA, overrun=1; ovr_clr -> overrun=0.
//  5 3 bits of a word, then sd_start with 0,1,1,0 -> P=4'b0110, no error; gaps with
//    sd_en=0 between bits do not change result.
//  6 DESER_PARITY_EN: data 4'b1011 + parity 1 -> parity_err=0; parity 0 -> parity_err=1.

Source files
------------

// File: rtl/shift_deserializer.sv
// shift_deserializer: receive end of the shift-register serial link.
// Collects a strobed bit stream into a shift register and presents each
// finished word on P with a valid/ready handshake. The shift register and
// the output holding register are separate, so reception carries on while
// a finished word waits for the consumer.
// Optional feature macro: DESER_PARITY_EN (one even-parity bit per word).
module shift_deserializer #(
    parameter int WIDTH     = 4,  // data bits per word, >= 2
    parameter bit MSB_FIRST = 1'b1  // 1: first bit lands in P[WIDTH-1]; 0: in P[0]
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             sd_in,
    input  logic             sd_en,
    input  logic             sd_start,
    input  logic             p_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] P,
    output logic             p_valid,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;
`endif

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_p;
    logic             r_p_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_in;   // shift register with this bit appended
    logic [WIDTH-1:0] w_fresh;      // empty shift register with this bit as bit 0
    logic [WIDTH-1:0] w_word;       // word finished on this edge
    logic             w_data_bit;   // strobe carrying a non-start bit
    logic             w_last_data;  // next sampled data bit is the final one
    logic             w_complete;   // a word finishes on this edge
    logic             w_load;       // finished word goes into P
    logic             w_drop;       // finished word is lost, P still occupied
`ifdef DESER_PARITY_EN
    logic             w_perr;
    logic             r_perr;
`endif

    // Next shift-register contents and word-completion decode.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        w_shift_in  = '0;
        w_fresh     = '0;
        w_word      = '0;
        w_complete  = 1'b0;
        w_data_bit  = sd_en && !sd_start;
        w_last_data = (r_state == RECV) && (r_cnt == CW'(WIDTH - 1));

        if (MSB_FIRST) begin
            w_shift_in = {r_shift[WIDTH-2:0], sd_in};
            w_fresh    = {{(WIDTH-1){1'b0}}, sd_in};
        end else begin
            w_shift_in = {sd_in, r_shift[WIDTH-1:1]};
            w_fresh    = {sd_in, {(WIDTH-1){1'b0}}};
        end

`ifdef DESER_PARITY_EN
        // The parity bit is not shifted in; the data bits are already in place.
        w_complete = w_data_bit && (r_state == PAR);
        w_word     = r_shift;
        w_perr     = (^r_shift) ^ sd_in;
`else
        w_complete = w_data_bit && w_last_data;
        w_word     = w_shift_in;
`endif

        w_load = w_complete && (!r_p_valid || p_ready);
        w_drop = w_complete && r_p_valid && !p_ready;
    end

    // Receive FSM: bit counting, shifting and restart on sd_start.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (sd_en) begin
            if (sd_start) begin
                // A start strobe always begins a new word, abandoning any partial one.
                // NOTE: sequential state uses <= so every register sees pre-edge values.
                r_state <= RECV;
                r_cnt   <= CW'(1);
                r_shift <= w_fresh;
            end else begin
                case (r_state)
                    IDLE: begin
                        // Stray bits outside a word are ignored.
                    end
                    RECV: begin
                        r_shift <= w_shift_in;
                        if (w_last_data) begin
                            r_cnt <= '0;
`ifdef DESER_PARITY_EN
                            r_state <= PAR;
`else
                            r_state <= IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
`ifdef DESER_PARITY_EN
                    PAR: begin
                        r_state <= IDLE;
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Output holding register, handshake and sticky overrun flag.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_p       <= w_word;
                r_p_valid <= 1'b1;
            end else if (r_p_valid && p_ready) begin
                r_p_valid <= 1'b0;
            end

            // A drop in the same cycle as ovr_clr leaves the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Parity status travels with the word held in P.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= w_perr;
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign P       = r_p;
    assign p_valid = r_p_valid;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_shift_deserializer.sv
// Testbench for shift_deserializer: one MSB-first and one LSB-first instance
// share every input; a table of directed vectors plus hand-written sequences
// for asynchronous reset and the parity option (DESER_PARITY_EN).
module tb_shift_deserializer;

    logic       clk;
    logic       clr;
    logic       sd_in;
    logic       sd_en;
    logic       sd_start;
    logic       p_ready;
    logic       ovr_clr;

    logic [3:0] p_m;
    logic       v_m;
    logic       ov_m;
    logic       pe_m;
    logic [3:0] p_l;
    logic       v_l;
    logic       ov_l;
    logic       pe_l;

    shift_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .CLR(clr), .sd_in(sd_in), .sd_en(sd_en), .sd_start(sd_start),
        .p_ready(p_ready), .ovr_clr(ovr_clr),
        .P(p_m), .p_valid(v_m), .overrun(ov_m), .parity_err(pe_m)
    );

    shift_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .CLR(clr), .sd_in(sd_in), .sd_en(sd_en), .sd_start(sd_start),
        .p_ready(p_ready), .ovr_clr(ovr_clr),
        .P(p_l), .p_valid(v_l), .overrun(ov_l), .parity_err(pe_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       st;
        logic       din;
        logic       rdy;
        logic       oc;
        logic [3:0] p_m;
        logic [3:0] p_l;
        logic       v;
        logic       ov;
        logic       pe;
    } vec_t;

    vec_t tbl[160];
    int   n_tbl = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    // Expected state as of the last table entry, used by the hold helpers.
    logic [3:0] e_pm = '0;
    logic [3:0] e_pl = '0;
    logic       e_v  = 1'b0;
    logic       e_ov = 1'b0;
    logic       e_pe = 1'b0;

    task automatic add(input logic en, input logic st, input logic din, input logic rdy,
                       input logic oc, input logic [3:0] pm, input logic [3:0] pl,
                       input logic v, input logic ov, input logic pe);
        tbl[n_tbl] = '{en, st, din, rdy, oc, pm, pl, v, ov, pe};
        n_tbl++;
        e_pm = pm; e_pl = pl; e_v = v; e_ov = ov; e_pe = pe;
    endtask

    // Vector whose edge must leave every output unchanged.
    task automatic hold(input logic en, input logic st, input logic din, input logic rdy,
                        input logic oc);
        add(en, st, din, rdy, oc, e_pm, e_pl, e_v, e_ov, e_pe);
    endtask

    // Final data bit of a word; with parity enabled the word completes on the
    // following parity strobe instead.
    task automatic last(input logic din, input logic par, input logic rdy, input logic oc,
                        input logic [3:0] pm, input logic [3:0] pl,
                        input logic v, input logic ov, input logic pe);
`ifdef DESER_PARITY_EN
        hold(1'b1, 1'b0, din, 1'b0, 1'b0);
        add(1'b1, 1'b0, par, rdy, oc, pm, pl, v, ov, pe);
`else
        add(1'b1, 1'b0, din, rdy, oc, pm, pl, v, ov, pe);
`endif
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, return at
    // the next falling edge where outputs are stable.
    task automatic step(input logic en, input logic st, input logic din, input logic rdy,
                        input logic oc);
        sd_en = en; sd_start = st; sd_in = din; p_ready = rdy; ovr_clr = oc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] pm, input logic [3:0] pl,
                         input logic v, input logic ov, input logic pe);
        n_vec++;
        if (p_m !== pm || p_l !== pl || v_m !== v || v_l !== v || ov_m !== ov ||
            ov_l !== ov || pe_m !== pe || pe_l !== pe) begin
            n_bad++;
            $display("FAIL %s: got P=%b/%b valid=%b/%b ovr=%b/%b perr=%b/%b, want P=%b/%b valid=%b ovr=%b perr=%b",
                     name, p_m, p_l, v_m, v_l, ov_m, ov_l, pe_m, pe_l, pm, pl, v, ov, pe);
        end
    endtask

    // Sends a word first bit = w[3]; data strobes carry rdy.
    task automatic send_word(input logic [3:0] w, input logic par, input logic rdy);
        step(1'b1, 1'b1, w[3], rdy, 1'b0);
        for (int i = 2; i >= 0; i--) step(1'b1, 1'b0, w[i], rdy, 1'b0);
`ifdef DESER_PARITY_EN
        step(1'b1, 1'b0, par, rdy, 1'b0);
`endif
    endtask

    initial begin
        clr = 1'b0; sd_in = 1'b0; sd_en = 1'b0; sd_start = 1'b0;
        p_ready = 1'b0; ovr_clr = 1'b0;

        // Stream 1,0,1,1 consumed at once.
        hold(1, 1, 1, 1, 0); hold(1, 0, 0, 1, 0); hold(1, 0, 1, 1, 0);
        last(1, 1, 1, 0, 4'b1011, 4'b1101, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b1011, 4'b1101, 0, 0, 0);
        hold(0, 0, 0, 1, 0);
        hold(1, 0, 1, 1, 0);                       // stray bit while idle
        // 4'hA held, then 4'h5 dropped, then overrun cleared and word consumed.
        hold(1, 1, 1, 0, 0); hold(1, 0, 0, 0, 0); hold(1, 0, 1, 0, 0);
        last(0, 0, 0, 0, 4'b1010, 4'b0101, 1, 0, 0);
        hold(0, 0, 0, 0, 0);
        hold(1, 1, 0, 0, 0); hold(1, 0, 1, 0, 0); hold(1, 0, 0, 0, 0);
        last(1, 0, 0, 0, 4'b1010, 4'b0101, 1, 1, 0);
        hold(0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 4'b1010, 4'b0101, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b1010, 4'b0101, 0, 0, 0);
        // Partial word abandoned by a restart, sd_en gaps inside the new word.
        hold(1, 1, 1, 1, 0); hold(1, 0, 1, 1, 0); hold(1, 0, 1, 1, 0);
        hold(1, 1, 0, 1, 0); hold(0, 0, 1, 1, 0); hold(1, 0, 1, 1, 0);
        hold(0, 0, 0, 1, 0); hold(0, 0, 0, 1, 0); hold(1, 0, 1, 1, 0);
        hold(0, 0, 1, 1, 0);
        last(0, 0, 1, 0, 4'b0110, 4'b0110, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b0110, 4'b0110, 0, 0, 0);
        // Consumer accepts on the same edge a new word completes.
        hold(1, 1, 1, 0, 0); hold(1, 0, 0, 0, 0); hold(1, 0, 1, 0, 0);
        last(1, 1, 0, 0, 4'b1011, 4'b1101, 1, 0, 0);
        hold(1, 1, 0, 0, 0); hold(1, 0, 1, 0, 0); hold(1, 0, 1, 0, 0);
        last(0, 0, 1, 0, 4'b0110, 4'b0110, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b0110, 4'b0110, 0, 0, 0);
        // Drop in the ovr_clr cycle: set wins.
        hold(1, 1, 1, 0, 0); hold(1, 0, 0, 0, 0); hold(1, 0, 1, 0, 0);
        last(1, 1, 0, 0, 4'b1011, 4'b1101, 1, 0, 0);
        hold(1, 1, 0, 0, 0); hold(1, 0, 1, 0, 0); hold(1, 0, 1, 0, 0);
        last(0, 0, 0, 1, 4'b1011, 4'b1101, 1, 1, 0);
        add(0, 0, 0, 0, 1, 4'b1011, 4'b1101, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'b1011, 4'b1101, 0, 0, 0);

        // Reset state is visible with no clock edge.
        #1;
        check("reset_state", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #11 clr = 1'b1;
        @(negedge clk);

        for (int i = 0; i < n_tbl; i++) begin
            step(tbl[i].en, tbl[i].st, tbl[i].din, tbl[i].rdy, tbl[i].oc);
            check($sformatf("vec%0d", i), tbl[i].p_m, tbl[i].p_l, tbl[i].v, tbl[i].ov, tbl[i].pe);
        end

`ifdef DESER_PARITY_EN
        // Wrong parity flagged, correct parity clean.
        send_word(4'b1011, 1'b0, 1'b1);
        check("par_bad", 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b1);
        step(0, 0, 0, 1, 0);
        check("par_bad_consumed", 4'b1011, 4'b1101, 1'b0, 1'b0, 1'b1);
        send_word(4'b1011, 1'b1, 1'b1);
        check("par_good", 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, 1, 0);
        // Status of a dropped word does not reach parity_err.
        send_word(4'b0110, 1'b1, 1'b0);
        check("par_bad_held", 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b1);
        send_word(4'b1010, 1'b0, 1'b0);
        check("par_drop_keeps", 4'b0110, 4'b0110, 1'b1, 1'b1, 1'b1);
        step(0, 0, 0, 1, 1);
        check("par_clear", 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-word with a held word and overrun pending.
        send_word(4'b1010, 1'b0, 1'b0);
        check("pre_reset_word", 4'b1010, 4'b0101, 1'b1, 1'b0, 1'b0);
        send_word(4'b0101, 1'b0, 1'b0);
        check("pre_reset_ovr", 4'b1010, 4'b0101, 1'b1, 1'b1, 1'b0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        #2 clr = 1'b0;
        #1;
        check("async_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1 clr = 1'b1;
        @(negedge clk);
        // Remaining bits of the discarded word carry no start and are ignored.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 0);
        check("partial_discarded", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
